// File: rtl/axi_stripe_read_burst_if.sv
// Bus bundle for the striped read front-end: the upstream burst read port plus NUM_S
// single-beat subordinate read ports. The slave modport is the front-end's view.
interface axi_stripe_read_burst_if #(
    parameter int NUM_S           = 2,
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ARLEN_WIDTH = 8
);
    // Every channel uses AXI valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both high; a source keeps valid and its payload stable until then.
    logic [AXI_ADDR_WIDTH-1:0]             in_axi_araddr;
    logic [AXI_ARLEN_WIDTH-1:0]            in_axi_arlen;
    logic                                  in_axi_arvalid;
    logic                                  in_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]             in_axi_rdata;
    logic [1:0]                            in_axi_rresp;
    logic                                  in_axi_rvalid;
    logic                                  in_axi_rlast;
    logic                                  in_axi_rready;

    logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0]  out_axi_araddr;
    logic [NUM_S-1:0]                      out_axi_arvalid;
    logic [NUM_S-1:0]                      out_axi_arready;
    logic [NUM_S-1:0][AXI_DATA_WIDTH-1:0]  out_axi_rdata;
    logic [NUM_S-1:0][1:0]                 out_axi_rresp;
    logic [NUM_S-1:0]                      out_axi_rvalid;
    logic [NUM_S-1:0]                      out_axi_rready;

    logic                                  dbg_state;

    modport slave (
        input  in_axi_araddr, in_axi_arlen, in_axi_arvalid, in_axi_rready,
               out_axi_arready, out_axi_rdata, out_axi_rresp, out_axi_rvalid,
        output in_axi_arready, in_axi_rdata, in_axi_rresp, in_axi_rvalid, in_axi_rlast,
               out_axi_araddr, out_axi_arvalid, out_axi_rready, dbg_state
    );

    modport master (
        output in_axi_araddr, in_axi_arlen, in_axi_arvalid, in_axi_rready,
               out_axi_arready, out_axi_rdata, out_axi_rresp, out_axi_rvalid,
        input  in_axi_arready, in_axi_rdata, in_axi_rresp, in_axi_rvalid, in_axi_rlast,
               out_axi_araddr, out_axi_arvalid, out_axi_rready, dbg_state
    );
endinterface

// File: rtl/axi_stripe_read_burst.sv
// Splits one AXI read burst into single-beat reads striped over NUM_S subordinates and
// restores beat order with per-subordinate FIFOs. Optional: AXI_STRIPE_READ_BURST_STICKY_RESP_EN.
module axi_stripe_read_burst #(
    parameter int NUM_S           = 2,
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ARLEN_WIDTH = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input logic                    axi_clk,
    input logic                    axi_resetn,
    axi_stripe_read_burst_if.slave bus
);
    localparam int SEL_BITS = $clog2(NUM_S);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = AXI_ARLEN_WIDTH + 1;
    localparam int ENT_BITS = AXI_DATA_WIDTH + 2;
    localparam logic [PTR_BITS:0] CREDIT_MAX = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS:0] FULL_XOR   = {1'b1, {PTR_BITS{1'b0}}};

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]                           state;
    logic                                 arready_q;
    logic [SEL_BITS-1:0]                  base_lo;
    logic [AXI_ARLEN_WIDTH-1:0]           len_q;
    logic [AXI_ARLEN_WIDTH-1:0]           ret_q;

    logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0] addr_q;
    logic [NUM_S-1:0][CNT_BITS-1:0]       cnt_q;
    logic [NUM_S-1:0][PTR_BITS:0]         credit_q;
    logic [NUM_S-1:0][PTR_BITS:0]         wptr_q;
    logic [NUM_S-1:0][PTR_BITS:0]         rptr_q;
    logic [ENT_BITS-1:0]                  mem [NUM_S][FIFO_DEPTH];

    logic [NUM_S-1:0][SEL_BITS-1:0]       start_d;
    logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0] start_addr;
    logic [NUM_S-1:0][CNT_BITS-1:0]       start_cnt;
    logic [NUM_S-1:0]                     issue, fire, full, empty, push, pop;

    logic                                 accept;
    logic [SEL_BITS-1:0]                  rsel;
    logic [PTR_BITS-1:0]                  rd_idx;
    logic [ENT_BITS-1:0]                  head;
    logic [1:0]                           resp_out;
    logic                                 rvalid;
    logic                                 beat_fire;
    logic                                 beat_last;

    assign accept    = bus.in_axi_arvalid && arready_q;
    assign rsel      = base_lo + ret_q[SEL_BITS-1:0];
    assign rd_idx    = rptr_q[rsel][PTR_BITS-1:0];
    assign head      = mem[rsel][rd_idx];
    assign rvalid    = (state == S_ACTIVE) && !empty[rsel];
    assign beat_fire = rvalid && bus.in_axi_rready;
    assign beat_last = (ret_q == len_q);

    // Offset d of each subordinate's first word from the base, and its share of the burst.
    always_comb begin
        start_d    = '0;
        start_addr = '0;
        start_cnt  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            start_d[s]    = SEL_BITS'(s) - bus.in_axi_araddr[SEL_BITS-1:0];
            start_addr[s] = bus.in_axi_araddr + AXI_ADDR_WIDTH'(start_d[s]);
            if (AXI_ARLEN_WIDTH'(start_d[s]) <= bus.in_axi_arlen)
                start_cnt[s] = CNT_BITS'((bus.in_axi_arlen - AXI_ARLEN_WIDTH'(start_d[s])) >> SEL_BITS)
                               + CNT_BITS'(1);
        end
    end

    always_comb begin
        issue = '0;
        fire  = '0;
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        for (int s = 0; s < NUM_S; s++) begin
            issue[s] = (cnt_q[s] != '0) && (credit_q[s] < CREDIT_MAX);
            fire[s]  = issue[s] && bus.out_axi_arready[s];
            full[s]  = ((wptr_q[s] ^ rptr_q[s]) == FULL_XOR);
            empty[s] = (wptr_q[s] == rptr_q[s]);
            push[s]  = bus.out_axi_rvalid[s] && !full[s];
            pop[s]   = beat_fire && (rsel == SEL_BITS'(s));
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state     <= S_IDLE;
            arready_q <= 1'b0;
            base_lo   <= '0;
            len_q     <= '0;
            ret_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_ACTIVE;
                        arready_q <= 1'b0;
                        base_lo   <= bus.in_axi_araddr[SEL_BITS-1:0];
                        len_q     <= bus.in_axi_arlen;
                        ret_q     <= '0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (beat_fire) begin
                        if (beat_last) begin
                            state     <= S_IDLE;
                            arready_q <= 1'b1;
                            ret_q     <= '0;
                        end else begin
                            ret_q <= ret_q + AXI_ARLEN_WIDTH'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Credit covers both in-flight requests and buffered beats, so a push never finds a full FIFO.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            credit_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            for (int s = 0; s < NUM_S; s++) begin
                if (accept) begin
                    addr_q[s] <= start_addr[s];
                    cnt_q[s]  <= start_cnt[s];
                end else if (fire[s]) begin
                    addr_q[s] <= addr_q[s] + AXI_ADDR_WIDTH'(NUM_S);
                    cnt_q[s]  <= cnt_q[s] - CNT_BITS'(1);
                end
                if (fire[s] && !pop[s])
                    credit_q[s] <= credit_q[s] + (PTR_BITS+1)'(1);
                else if (!fire[s] && pop[s])
                    credit_q[s] <= credit_q[s] - (PTR_BITS+1)'(1);
                if (push[s])
                    wptr_q[s] <= wptr_q[s] + (PTR_BITS+1)'(1);
                if (pop[s])
                    rptr_q[s] <= rptr_q[s] + (PTR_BITS+1)'(1);
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        for (int s = 0; s < NUM_S; s++) begin
            if (push[s])
                mem[s][wptr_q[s][PTR_BITS-1:0]] <= {bus.out_axi_rdata[s], bus.out_axi_rresp[s]};
        end
    end

`ifdef AXI_STRIPE_READ_BURST_STICKY_RESP_EN
    logic [1:0] sticky_q;

    assign resp_out = (head[1:0] > sticky_q) ? head[1:0] : sticky_q;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn)
            sticky_q <= '0;
        else if (state == S_IDLE)
            sticky_q <= '0;
        else if (beat_fire)
            sticky_q <= resp_out;
    end
`else
    assign resp_out = head[1:0];
`endif

    // Payload is gated so the output reads zero whenever no beat is presented.
    assign bus.in_axi_arready  = arready_q;
    assign bus.in_axi_rvalid   = rvalid;
    assign bus.in_axi_rdata    = rvalid ? head[ENT_BITS-1:2] : '0;
    assign bus.in_axi_rresp    = rvalid ? resp_out : 2'b00;
    assign bus.in_axi_rlast    = rvalid && beat_last;
    assign bus.out_axi_araddr  = addr_q;
    assign bus.out_axi_arvalid = issue;
    assign bus.out_axi_rready  = ~full;
    assign bus.dbg_state       = state[0];
endmodule
